// File: rtl/i2s_clk_pkg.sv
// Shared types and helpers for the I2S bit-clock / LR-clock scheduler.
package i2s_clk_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } sched_state_t;

    // Width of the bit-in-frame counter for a given slot length.
    function automatic int bc_width(input int slot_bits);
        return $clog2(2 * slot_bits);
    endfunction

    // A zero divisor would stall the half-period counter, so it runs as 1.
    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        return (div == 32'd0) ? 32'd1 : div;
    endfunction

endpackage

// File: rtl/i2s_clk_sched_bclk_gen.sv
// Half-period counter and registered bclk with single-cycle rise/fall strobes.
module i2s_bclk_gen
    import i2s_clk_pkg::*;
#(
    parameter int DIV_W        = 8,
    parameter int DEF_HALF_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             load_div,
    input  logic [DIV_W-1:0] div,
    output logic             tick,
    output logic             bclk,
    output logic             bclk_rise,
    output logic             bclk_fall
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] hc_q, hc_d;
    logic [DIV_W-1:0] n_last;
    logic             started_q, started_d;
    logic             bclk_q, bclk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    assign n_last = DIV_W'(clamp_div(32'(div_q)) - 32'd1);

    // started_q holds the counter for one extra cycle after entering run,
    // which gives the first rise its N+1 cycle lead-in.
    assign tick = run && started_q && (hc_q == n_last);

    always_comb begin
        div_d     = load_div ? div : div_q;
        started_d = run;
        hc_d      = hc_q;
        bclk_d    = bclk_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        if (!run) begin
            hc_d   = '0;
            bclk_d = 1'b0;
        end else if (started_q) begin
            if (tick) begin
                hc_d   = '0;
                bclk_d = !bclk_q;
                rise_d = !bclk_q;
                fall_d = bclk_q;
            end else begin
                hc_d = hc_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= DIV_W'(DEF_HALF_DIV);
            hc_q      <= '0;
            started_q <= 1'b0;
            bclk_q    <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            div_q     <= div_d;
            hc_q      <= hc_d;
            started_q <= started_d;
            bclk_q    <= bclk_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
        end
    end

    assign bclk      = bclk_q;
    assign bclk_rise = rise_q;
    assign bclk_fall = fall_q;

endmodule

// File: rtl/i2s_clk_sched.sv
// I2S clock scheduler: run/stop FSM, bit/slot counting and frame-aligned divisor updates.
// Optional frame counter output enabled by defining I2S_SCHED_FRAME_CNT_EN.
module i2s_clk_sched
    import i2s_clk_pkg::*;
#(
    parameter int DIV_W        = 8,
    parameter int SLOT_BITS    = 32,
    parameter int DEF_HALF_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_half_div,
    output logic             bclk,
    output logic             lrclk,
    output logic             bclk_rise,
    output logic             bclk_fall,
    output logic             frame_start,
    output logic             busy
`ifdef I2S_SCHED_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam int BC_W = bc_width(SLOT_BITS);
    localparam logic [BC_W-1:0] BC_MID  = BC_W'(SLOT_BITS - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(2 * SLOT_BITS - 1);

    sched_state_t     state_q, state_d;
    logic [BC_W-1:0]  bc_q, bc_d;
    logic             lrclk_q, lrclk_d;
    logic             fs_q, fs_d;
    logic             pend_valid_q, pend_valid_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             load_div;
    logic             run;
    logic             tick;
    logic             gen_bclk;
    logic             fall_evt;
    logic             boundary;

    assign run       = (state_q != IDLE);
    assign cfg_ready = !pend_valid_q;
    assign fall_evt  = tick && gen_bclk;
    assign boundary  = fall_evt && (bc_q == BC_LAST);

    i2s_bclk_gen #(
        .DIV_W        (DIV_W),
        .DEF_HALF_DIV (DEF_HALF_DIV)
    ) u_bclk_gen (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .load_div  (load_div),
        .div       (pend_div_q),
        .tick      (tick),
        .bclk      (gen_bclk),
        .bclk_rise (bclk_rise),
        .bclk_fall (bclk_fall)
    );

    always_comb begin
        state_d      = state_q;
        bc_d         = bc_q;
        lrclk_d      = lrclk_q;
        fs_d         = 1'b0;
        pend_valid_d = pend_valid_q;
        pend_div_d   = pend_div_q;
        load_div     = 1'b0;

        case (state_q)
            IDLE: begin
                bc_d    = '0;
                lrclk_d = 1'b0;
                if (enable) state_d = RUN;
            end
            RUN:      if (!enable) state_d = STOPPING;
            STOPPING: if (enable)  state_d = RUN;
            default:  state_d = IDLE;
        endcase

        if (fall_evt) begin
            if (boundary) begin
                bc_d    = '0;
                lrclk_d = 1'b0;
                // A stop lands on the frame boundary without announcing a new frame.
                if (state_q == STOPPING && !enable) state_d = IDLE;
                else                                fs_d    = 1'b1;
            end else begin
                bc_d = bc_q + BC_W'(1);
                if (bc_q == BC_MID) lrclk_d = 1'b1;
            end
        end

        if (pend_valid_q && (state_q == IDLE || boundary)) begin
            load_div     = 1'b1;
            pend_valid_d = 1'b0;
        end
        if (cfg_valid && cfg_ready) begin
            pend_valid_d = 1'b1;
            pend_div_d   = cfg_half_div;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bc_q         <= '0;
            lrclk_q      <= 1'b0;
            fs_q         <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_div_q   <= '0;
        end else begin
            state_q      <= state_d;
            bc_q         <= bc_d;
            lrclk_q      <= lrclk_d;
            fs_q         <= fs_d;
            pend_valid_q <= pend_valid_d;
            pend_div_q   <= pend_div_d;
        end
    end

    assign bclk        = gen_bclk;
    assign lrclk       = lrclk_q;
    assign frame_start = fs_q;
    assign busy        = run;

`ifdef I2S_SCHED_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb frame_cnt_d = fs_d ? frame_cnt_q + 16'd1 : frame_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_cnt_q <= '0;
        else     frame_cnt_q <= frame_cnt_d;
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_clk_sched.sv
// Scoreboard bench for i2s_clk_sched: expected strobe cycles queued per scenario, matched on the fly.
module tb_i2s_clk_sched;

    localparam int DIV_W = 8;
    localparam int K_RISE = 0;
    localparam int K_FALL = 1;
    localparam int K_FS   = 2;
    localparam int K_LR   = 3;

    logic             clk;
    logic             rst;
    logic             enable;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [DIV_W-1:0] cfg_half_div;
    logic             bclk;
    logic             lrclk;
    logic             bclk_rise;
    logic             bclk_fall;
    logic             frame_start;
    logic             busy;
`ifdef I2S_SCHED_FRAME_CNT_EN
    logic [15:0]      frame_cnt;
`endif

    i2s_clk_sched #(
        .DIV_W        (DIV_W),
        .SLOT_BITS    (4),
        .DEF_HALF_DIV (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_half_div (cfg_half_div),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .bclk_rise    (bclk_rise),
        .bclk_fall    (bclk_fall),
        .frame_start  (frame_start),
        .busy         (busy)
`ifdef I2S_SCHED_FRAME_CNT_EN
        ,
        .frame_cnt    (frame_cnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int mon_lo = 1000000;
    int mon_hi = -1;
    logic lr_prev = 1'b0;
    int rise_q[$];
    int fall_q[$];
    int fs_q[$];
    int lr_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int obs, input int expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic exp_evt(input int kind, input int t0, input int step, input int t_max);
        for (int t = t0; t <= t_max; t += step) begin
            case (kind)
                K_RISE:  rise_q.push_back(t);
                K_FALL:  fall_q.push_back(t);
                K_FS:    fs_q.push_back(t);
                default: lr_q.push_back(t);
            endcase
        end
    endtask

    task automatic flush_check(input string tag);
        check_eq({tag, "_rise_left"}, rise_q.size(), 0);
        check_eq({tag, "_fall_left"}, fall_q.size(), 0);
        check_eq({tag, "_fs_left"},   fs_q.size(),   0);
        check_eq({tag, "_lr_left"},   lr_q.size(),   0);
        rise_q.delete();
        fall_q.delete();
        fs_q.delete();
        lr_q.delete();
    endtask

    task automatic wait_lbl(input int l);
        while (cyc < l) @(negedge clk);
    endtask

    // Outputs are observed on the falling edge; each strobe pops its expected cycle.
    always @(negedge clk) begin
        if (cyc >= mon_lo && cyc <= mon_hi) begin
            if (bclk_rise) begin
                if (rise_q.size() > 0) check_eq("rise", cyc, rise_q.pop_front());
                else                   check_eq("rise_extra", cyc, -1);
            end
            if (bclk_fall) begin
                if (fall_q.size() > 0) check_eq("fall", cyc, fall_q.pop_front());
                else                   check_eq("fall_extra", cyc, -1);
            end
            if (frame_start) begin
                if (fs_q.size() > 0) check_eq("frame_start", cyc, fs_q.pop_front());
                else                 check_eq("frame_start_extra", cyc, -1);
            end
            if (lrclk && !lr_prev) begin
                if (lr_q.size() > 0) check_eq("lrclk_rise", cyc, lr_q.pop_front());
                else                 check_eq("lrclk_rise_extra", cyc, -1);
            end
            check_eq("strobe_excl", int'(bclk_rise & bclk_fall), 0);
            check_eq("fs_needs_fall", int'(frame_start & !bclk_fall), 0);
        end
        lr_prev = lrclk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e, s, i, s2, s3;
        rst          = 1'b1;
        enable       = 1'b0;
        cfg_valid    = 1'b0;
        cfg_half_div = '0;

        wait_lbl(1);
        check_eq("rst_bclk",  int'(bclk), 0);
        check_eq("rst_lrclk", int'(lrclk), 0);
        check_eq("rst_busy",  int'(busy), 0);
        check_eq("rst_rise",  int'(bclk_rise), 0);
        check_eq("rst_fall",  int'(bclk_fall), 0);
        check_eq("rst_fs",    int'(frame_start), 0);
        check_eq("rst_ready", int'(cfg_ready), 1);
        wait_lbl(3);
        rst = 1'b0;
        wait_lbl(4);
        check_eq("idle_bclk",  int'(bclk), 0);
        check_eq("idle_busy",  int'(busy), 0);
        check_eq("idle_ready", int'(cfg_ready), 1);

        // Default divisor 4, divisor 3 taken mid-frame, then stop inside a left slot.
        e = 10;
        exp_evt(K_RISE, e + 5,   8, e + 128);
        exp_evt(K_RISE, e + 132, 6, e + 222);
        exp_evt(K_FALL, e + 9,   8, e + 129);
        exp_evt(K_FALL, e + 135, 6, e + 225);
        exp_evt(K_FS,   e + 65,  64, e + 129);
        exp_evt(K_FS,   e + 177, 48, e + 177);
        exp_evt(K_LR,   e + 33,  64, e + 97);
        exp_evt(K_LR,   e + 153, 48, e + 201);
        mon_lo = e + 1;
        mon_hi = e + 240;
        wait_lbl(e - 1);
        enable = 1'b1;
        wait_lbl(e + 1);
        check_eq("run_busy", int'(busy), 1);
        wait_lbl(e + 99);
        check_eq("cfg_ready_before", int'(cfg_ready), 1);
        cfg_valid    = 1'b1;
        cfg_half_div = 8'd3;
        wait_lbl(e + 100);
        cfg_valid = 1'b0;
        check_eq("cfg_ready_pending", int'(cfg_ready), 0);
        wait_lbl(e + 110);
        cfg_valid    = 1'b1;
        cfg_half_div = 8'd0;
        wait_lbl(e + 111);
        check_eq("cfg_backpressure", int'(cfg_ready), 0);
        wait_lbl(e + 112);
        cfg_valid = 1'b0;
        wait_lbl(e + 128);
        check_eq("cfg_ready_pre_boundary", int'(cfg_ready), 0);
        wait_lbl(e + 129);
        check_eq("cfg_ready_at_boundary", int'(cfg_ready), 1);
        wait_lbl(e + 180);
        enable = 1'b0;
        wait_lbl(e + 224);
        check_eq("stopping_busy", int'(busy), 1);
        wait_lbl(e + 225);
        check_eq("stopped_busy",  int'(busy), 0);
        check_eq("stopped_bclk",  int'(bclk), 0);
        check_eq("stopped_lrclk", int'(lrclk), 0);
        wait_lbl(e + 241);
        flush_check("run1");

        // Divisor 3 retained; enable dropped and restored inside STOPPING.
        s = e + 250;
        exp_evt(K_RISE, s + 4,  6,  s + 94);
        exp_evt(K_FALL, s + 7,  6,  s + 97);
        exp_evt(K_FS,   s + 49, 48, s + 49);
        exp_evt(K_LR,   s + 25, 48, s + 73);
        mon_lo = s + 1;
        mon_hi = s + 105;
        wait_lbl(s - 1);
        enable = 1'b1;
        wait_lbl(s + 10);
        enable = 1'b0;
        wait_lbl(s + 15);
        check_eq("stopping_busy2", int'(busy), 1);
        wait_lbl(s + 20);
        enable = 1'b1;
        wait_lbl(s + 60);
        enable = 1'b0;
        wait_lbl(s + 96);
        check_eq("stopping_busy3", int'(busy), 1);
        wait_lbl(s + 97);
        check_eq("stopped_busy3", int'(busy), 0);
        wait_lbl(s + 106);
        flush_check("run2");

        // Zero divisor loaded in IDLE clamps to a period of 2.
        i = s + 110;
        wait_lbl(i);
        check_eq("idle_ready2", int'(cfg_ready), 1);
        cfg_valid    = 1'b1;
        cfg_half_div = 8'd0;
        wait_lbl(i + 1);
        check_eq("idle_pending", int'(cfg_ready), 0);
        cfg_valid = 1'b0;
        wait_lbl(i + 2);
        check_eq("idle_applied", int'(cfg_ready), 1);
        s2 = i + 4;
        exp_evt(K_RISE, s2 + 2,  2,  s2 + 40);
        exp_evt(K_FALL, s2 + 3,  2,  s2 + 39);
        exp_evt(K_FS,   s2 + 17, 16, s2 + 33);
        exp_evt(K_LR,   s2 + 9,  16, s2 + 25);
        mon_lo = s2 + 1;
        mon_hi = s2 + 40;
        wait_lbl(i + 3);
        enable = 1'b1;
        wait_lbl(s2 + 41);
        flush_check("run3");

        // Asynchronous reset inside the right slot.
        wait_lbl(s2 + 44);
        check_eq("right_slot_lrclk", int'(lrclk), 1);
        #2;
        rst    = 1'b1;
        enable = 1'b0;
        #1;
        check_eq("arst_bclk",  int'(bclk), 0);
        check_eq("arst_lrclk", int'(lrclk), 0);
        check_eq("arst_busy",  int'(busy), 0);
        check_eq("arst_rise",  int'(bclk_rise), 0);
        check_eq("arst_fall",  int'(bclk_fall), 0);
        check_eq("arst_fs",    int'(frame_start), 0);
        check_eq("arst_ready", int'(cfg_ready), 1);
        wait_lbl(s2 + 47);
        rst = 1'b0;

        s3 = s2 + 50;
        exp_evt(K_RISE, s3 + 5,  8, s3 + 70);
        exp_evt(K_FALL, s3 + 9,  8, s3 + 70);
        exp_evt(K_FS,   s3 + 65, 64, s3 + 65);
        exp_evt(K_LR,   s3 + 33, 64, s3 + 33);
        mon_lo = s3 + 1;
        mon_hi = s3 + 70;
        wait_lbl(s3 - 1);
        enable = 1'b1;
        wait_lbl(s3 + 20);
        check_eq("restart_lrclk", int'(lrclk), 0);
        wait_lbl(s3 + 71);
        flush_check("run4");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
